// File: rtl/multiport_reg_file.sv
// Parametrised multi-port register file with a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining MULTIPORT_RF_BYPASS_EN.
module multiport_reg_file #(
  parameter int unsigned DW    = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   wsel,
  input  logic [NWR*DW-1:0]   wdat,
  input  logic [NRD*AW-1:0]   rsel,
  output logic [NRD*DW-1:0]   rdat,
  output logic [NRD-1:0]      rbusy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_sel,
  output logic [NREGS-1:0]    busy_vec
);

  logic [DW-1:0]    regs   [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] wr_hit;
  logic [DW-1:0]    wr_val [NREGS];

  // Resolve write ports per register; later (higher-numbered) ports override earlier ones.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) wr_val[r] = '0;
    for (int i = 0; i < NWR; i++) begin
      if (wen[i] && (wsel[i*AW +: AW] != '0)) begin
        wr_hit[wsel[i*AW +: AW]] = 1'b1;
        wr_val[wsel[i*AW +: AW]] = wdat[i*DW +: DW];
      end
    end
  end

  // Register 0 is only ever touched by reset, so it stays zero and never busy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
        // A reservation is a newer producer than any write landing this cycle.
        if (rsv_en && (rsv_sel == AW'(r))) busy[r] <= 1'b1;
        else if (wr_hit[r])                 busy[r] <= 1'b0;
      end
    end
  end

  assign busy_vec = busy;

  // Combinational read ports.
  always_comb begin
    rdat  = '0;
    rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      rdat[j*DW +: DW] = regs[rsel[j*AW +: AW]];
      rbusy[j]         = busy[rsel[j*AW +: AW]];
`ifdef MULTIPORT_RF_BYPASS_EN
      for (int i = 0; i < NWR; i++) begin
        if (wen[i] && (wsel[i*AW +: AW] != '0) && (wsel[i*AW +: AW] == rsel[j*AW +: AW])) begin
          rdat[j*DW +: DW] = wdat[i*DW +: DW];
          rbusy[j]         = rsv_en && (rsv_sel == rsel[j*AW +: AW]);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_multiport_reg_file.sv
// Scoreboard bench for multiport_reg_file (NWR=2, NRD=2): stimulus queues expectations,
// a monitor drains and compares them on each falling edge or on an explicit sample event.
module tb_multiport_reg_file;

  localparam int unsigned DW = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;
  localparam int unsigned AW = 5;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NWR-1:0]    wen;
  logic [NWR*AW-1:0] wsel;
  logic [NWR*DW-1:0] wdat;
  logic [NRD*AW-1:0] rsel;
  logic [NRD*DW-1:0] rdat;
  logic [NRD-1:0]    rbusy;
  logic              rsv_en;
  logic [AW-1:0]     rsv_sel;
  logic [NREGS-1:0]  busy_vec;

  typedef struct {
    string       name;
    int          kind;   // 0: rdat[port], 1: rbusy[port], 2: busy_vec
    int          port;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  multiport_reg_file #(.DW(DW), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .CLK(CLK), .RST(RST), .wen(wen), .wsel(wsel), .wdat(wdat),
    .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .busy_vec(busy_vec)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input string n, input int k, input int p, input logic [31:0] e);
    chk_t c;
    c.name = n; c.kind = k; c.port = p; c.exp = e;
    q.push_back(c);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] sel, input logic [31:0] d);
    wen[p] = 1'b1;
    wsel[p*AW +: AW] = sel;
    wdat[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] sel);
    rsel[p*AW +: AW] = sel;
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    forever begin
      @(negedge CLK or chk_ev);
      while (q.size() > 0) begin
        chk_t c;
        logic [31:0] act;
        c = q.pop_front();
        case (c.kind)
          0:       act = rdat[c.port*DW +: DW];
          1:       act = {31'b0, rbusy[c.port]};
          default: act = busy_vec;
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; wen = '0; wsel = '0; wdat = '0; rsel = '0; rsv_en = 1'b0; rsv_sel = '0;

    // 1. Reset holds everything at zero despite writes and reservations.
    wr(0, 5'd5, 32'hFFFF_0001);
    wr(1, 5'd9, 32'hFFFF_0002);
    rsv_en = 1'b1; rsv_sel = 5'd9;
    rd(0, 5'd5); rd(1, 5'd9);
    step();
    push("rst_rdat0", 0, 0, 32'h0);
    push("rst_rdat1", 0, 1, 32'h0);
    push("rst_rbusy1", 1, 1, 32'h0);
    push("rst_busy_vec", 2, 0, 32'h0);
    step();
    RST = 1'b0; wen = '0; rsv_en = 1'b0;
    for (int r = 1; r < 32; r += 2) begin
      rd(0, AW'(r)); rd(1, AW'(r + 1));
      push($sformatf("post_rst_r%0d", r), 0, 0, 32'h0);
      push($sformatf("post_rst_r%0d", r + 1), 0, 1, 32'h0);
      step();
    end

    // 2. Basic write/read, and writes to r0 are ignored.
    wr(0, 5'd5, 32'hDEAD_BEEF);
    step();
    wen = '0; rd(0, 5'd5); rd(1, 5'd5);
    push("rd_r5_p0", 0, 0, 32'hDEAD_BEEF);
    push("rd_r5_p1", 0, 1, 32'hDEAD_BEEF);
    wr(0, 5'd0, 32'h0000_1234);
    step();
    wen = '0; rd(0, 5'd0);
    push("rd_r0", 0, 0, 32'h0);
    push("rbusy_r0", 1, 0, 32'h0);
    step();

    // 3. Port conflict: higher-numbered port wins.
    wr(0, 5'd7, 32'h0000_AAAA);
    wr(1, 5'd7, 32'h0000_5555);
    step();
    wen = '0; rd(0, 5'd7);
    push("conflict_r7", 0, 0, 32'h0000_5555);
    step();

    // 4. Scoreboard reserve / clear / reserve-wins / r0 ignored.
    rsv_en = 1'b1; rsv_sel = 5'd9;
    step();
    rsv_en = 1'b0; rd(1, 5'd9);
    push("rsv_busy_vec", 2, 0, 32'h0000_0200);
    push("rsv_rbusy1", 1, 1, 32'h1);
    wr(0, 5'd9, 32'h0000_0042);
    step();
    wen = '0;
    push("wb_busy_vec", 2, 0, 32'h0);
    push("wb_rdat1", 0, 1, 32'h0000_0042);
    push("wb_rbusy1", 1, 1, 32'h0);
    wr(1, 5'd9, 32'h0000_0043);
    rsv_en = 1'b1; rsv_sel = 5'd9;
    step();
    wen = '0;
    push("rsvwr_busy_vec", 2, 0, 32'h0000_0200);
    push("rsvwr_rdat1", 0, 1, 32'h0000_0043);
    step();
    rsv_en = 1'b0;
    push("rerserve_busy_vec", 2, 0, 32'h0000_0200);
    wr(0, 5'd9, 32'h0000_0044);
    rsv_en = 1'b1; rsv_sel = 5'd0;
    step();
    wen = '0; rsv_en = 1'b0;
    push("rsv_r0_busy_vec", 2, 0, 32'h0);
    push("clr_rdat1", 0, 1, 32'h0000_0044);
    step();

    // 5. Same-cycle write visibility.
    wr(0, 5'd3, 32'h0000_0011);
    step();
    wr(0, 5'd3, 32'h0000_0077);
    rd(0, 5'd3);
`ifdef MULTIPORT_RF_BYPASS_EN
    push("bypass_same_cycle", 0, 0, 32'h0000_0077);
`else
    push("bypass_same_cycle", 0, 0, 32'h0000_0011);
`endif
    push("bypass_rbusy0", 1, 0, 32'h0);
    step();
    wen = '0;
    push("bypass_next_cycle", 0, 0, 32'h0000_0077);
    step();

    // 6. Asynchronous reset mid-cycle.
    wr(0, 5'd4, 32'h0000_0099);
    rsv_en = 1'b1; rsv_sel = 5'd4;
    step();
    wen = '0; rsv_en = 1'b0; rd(0, 5'd4);
    push("pre_arst_rdat0", 0, 0, 32'h0000_0099);
    push("pre_arst_busy_vec", 2, 0, 32'h0000_0010);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    push("arst_rdat0", 0, 0, 32'h0);
    push("arst_rbusy0", 1, 0, 32'h0);
    push("arst_busy_vec", 2, 0, 32'h0);
    ->chk_ev;
    step();
    RST = 1'b0;
    push("post_arst_rdat0", 0, 0, 32'h0);
    step();

    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiport_reg_file.md
Name: multiport_reg_file

Overview:
- Parametrised successor to the single-write, dual-read CPU register file.
- Configurable data width, register count, read-port count and write-port count.
- Adds a per-register busy scoreboard: issue logic reserves a destination, and writeback clears the reservation.
- Sits between decode/issue (reads, reserve) and writeback (writes) in the pipelined and superscalar datapaths.

Parameters:
DW, 32, data width in bits per register
NREGS, 32, number of architectural registers (power of 2, >=2)
NRD, 2, number of read ports
NWR, 1, number of write ports
AW, $clog2(NREGS), register index width (derived, do not override)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous active-high reset
wen  input  NWR  per-write-port enable
wsel  input  NWR*AW  per-write-port destination index; port i in bits [i*AW +: AW]
wdat  input  NWR*DW  per-write-port data; port i in bits [i*DW +: DW]
rsel  input  NRD*AW  per-read-port source index
rdat  output  NRD*DW  per-read-port data
rbusy  output  NRD  per-read-port busy flag of the selected register
rsv_en  input  1  reserve destination (issue)
rsv_sel  input  AW  register to reserve
busy_vec  output  NREGS  full scoreboard, bit r = register r busy

Behaviour:
- One clock; reset is asynchronous and active-high.
- While RST=1: all registers 0, all busy bits 0. Hence every rdat=0, every rbusy=0, busy_vec=0. Asserting RST mid-operation discards pending writes and reservations immediately.
- Register 0 is hardwired zero:
  - Writes to index 0 are ignored.
  - Reservations of index 0 are ignored; busy_vec[0] is always 0.
  - Reads of index 0 return 0 with rbusy=0.
- Write timing: at the rising edge, every port with wen[i]=1 and wsel[i]!=0 writes wdat[i] into the register. With the feature disabled, the new value appears on rdat the cycle after the write.
- Write conflicts: if several ports target the same register in the same cycle, the highest-numbered port wins. The other ports are dropped silently.
- Read: rdat[j] and rbusy[j] are combinational from the register array (and scoreboard) indexed by rsel[j]. Any number of ports may read the same register.
- Scoreboard update per register r at each rising edge:
  - set if rsv_en=1 and rsv_sel==r;
  - otherwise cleared if any write port writes r this cycle;
  - otherwise held.
- Simultaneous reserve and write of the same register: busy ends at 1. Reserve wins because it represents a newer producer. The data write still occurs.
- A write to a non-busy register is legal: data updates and busy stays 0.
- Reserving an already-busy register is legal: busy stays 1. No count is kept; a single write clears it.
- No other state exists; there is no stall or back-pressure output.

Optional Feature:
Macro: MULTIPORT_RF_BYPASS_EN
- Defined: write-to-read forwarding.
  - If a read port's rsel equals the wsel of an enabled write port (index !=0) in the same cycle, rdat returns that wdat, using the highest-numbered matching port.
  - rbusy for that port reads 0, unless rsv_en with an equal rsv_sel is also active, in which case rbusy=1.
  - Array and scoreboard update timing is unchanged.
- Undefined: rdat and rbusy reflect only stored state. A same-cycle write is visible next cycle.

Test Plan:
1. Reset: hold RST=1, drive random writes and reservations -> all rdat=0, busy_vec=0. Release RST; read r1..r31 -> all 0.
2. Basic write/read: wen[0]=1, wsel=5, wdat=0xDEADBEEF; next cycle rsel[0]=5, rsel[1]=5 -> both rdat=0xDEADBEEF. Write 0x1234 to r0 -> reads of r0 return 0.
3. Port conflict (NWR=2): both ports write r7, port0=0xAAAA, port1=0x5555 -> r7=0x5555.
4. Scoreboard: rsv_en, rsv_sel=9 -> next cycle busy_vec[9]=1 and rbusy=1 on a port with rsel=9. Write r9=0x42 -> next cycle busy_vec[9]=0, rdat=0x42. Reserve and write r9 in the same cycle -> busy_vec[9]=1, r9 holds the new data. rsv_sel=0 -> busy_vec stays 0.
5. Bypass: rsel[0]=3 while wen[0]=1, wsel=3, wdat=0x77. With MULTIPORT_RF_BYPASS_EN -> rdat[0]=0x77 in the same cycle. Without it -> old value, then 0x77 the next cycle.
6. Mid-operation reset: r4=0x99 and r4 busy; pulse RST asynchronously between edges -> rdat(r4)=0 and busy_vec=0 immediately, without waiting for a clock edge.
